// File: rtl/skein512_ubi_iter.sv
// Iterative Threefish-512 block engine with optional UBI feed-forward.
// One 512-bit block per transaction; UNROLL rounds per clock, valid/ready on both sides.
module skein512_ubi_iter #(
  parameter int UNROLL       = 4,
  parameter int FEED_FORWARD = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_key,
  input  logic [127:0] in_tweak,
  input  logic [511:0] in_msg,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] out_data,
  output logic         busy
);

  generate
    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8)) begin : g_bad_unroll
      $error("skein512_ubi_iter: UNROLL must be 1, 2, 4 or 8");
    end
  endgenerate

  localparam logic [1:0]  S_IDLE    = 2'd0;
  localparam logic [1:0]  S_RUN     = 2'd1;
  localparam logic [1:0]  S_DONE    = 2'd2;
  localparam logic [6:0]  ROUNDS    = 7'd72;
  localparam logic [6:0]  STEP      = 7'(UNROLL);
  localparam logic [63:0] KS_PARITY = 64'h1BD11BDAA9FC1A22;
  localparam int          PI [8]    = '{2, 1, 4, 7, 6, 5, 0, 3};

  function automatic logic [63:0] rotl64(input logic [63:0] x, input logic [5:0] r);
    return (x << r) | (x >> (7'd64 - {1'b0, r}));
  endfunction

  // Skein 1.3 rotation constants; row holds j=3..0 from MSB to LSB.
  function automatic logic [5:0] rot_amt(input logic [2:0] row, input logic [1:0] j);
    logic [23:0] r;
    case (row)
      3'd0:    r = {6'd37, 6'd19, 6'd36, 6'd46};
      3'd1:    r = {6'd42, 6'd14, 6'd27, 6'd33};
      3'd2:    r = {6'd39, 6'd36, 6'd49, 6'd17};
      3'd3:    r = {6'd56, 6'd54, 6'd9,  6'd44};
      3'd4:    r = {6'd24, 6'd34, 6'd30, 6'd39};
      3'd5:    r = {6'd17, 6'd10, 6'd50, 6'd13};
      3'd6:    r = {6'd43, 6'd39, 6'd29, 6'd25};
      default: r = {6'd22, 6'd56, 6'd35, 6'd8};
    endcase
    case (j)
      2'd0:    return r[5:0];
      2'd1:    return r[11:6];
      2'd2:    return r[17:12];
      default: return r[23:18];
    endcase
  endfunction

  logic [1:0]   state_q, state_d;
  logic [6:0]   rnd_q, rnd_d;
  logic [511:0] out_q, out_d;
  logic [511:0] v_q, msg_q;
  logic [575:0] key_q;
  logic [191:0] tw_q;

  logic         accept, last_run;
  logic [63:0]  k8_w;
  logic [511:0] v0_w;
  logic [575:0] key_ld_w;
  logic [191:0] tw_ld_w;

  logic [511:0] v_w, mx_w, res_w;
  logic [575:0] k_w;
  logic [191:0] t_w;
  logic [6:0]   d_w;
  logic [4:0]   s_w;
  logic [63:0]  sk_w;

  assign in_ready  = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign last_run  = (state_q == S_RUN) & (rnd_q == ROUNDS - STEP);
  assign busy      = (state_q == S_RUN);
  assign out_valid = (state_q == S_DONE);
  assign out_data  = out_q;

  // Block load: k8 parity word, tweak t2, and v = M + subkey 0.
  always_comb begin
    k8_w = KS_PARITY;
    v0_w = '0;
    for (int i = 0; i < 8; i++) begin
      k8_w = k8_w ^ in_key[64*i +: 64];
      v0_w[64*i +: 64] = in_msg[64*i +: 64] + in_key[64*i +: 64];
    end
    v0_w[64*5 +: 64] = v0_w[64*5 +: 64] + in_tweak[63:0];
    v0_w[64*6 +: 64] = v0_w[64*6 +: 64] + in_tweak[127:64];
  end

  // Schedules stored already rotated past subkey 0, ready for injection 1.
  assign key_ld_w = {in_key[63:0], k8_w, in_key[511:64]};
  assign tw_ld_w  = {in_tweak[63:0], in_tweak[63:0] ^ in_tweak[127:64], in_tweak[127:64]};

  // NOTE: combinational chains use blocking '=' so each round sees the previous
  // round's result within the same cycle; registers below use '<=' only.
  always_comb begin
    v_w  = v_q;
    mx_w = v_q;
    k_w  = key_q;
    t_w  = tw_q;
    d_w  = rnd_q;
    s_w  = '0;
    sk_w = '0;
    for (int u = 0; u < UNROLL; u++) begin
      d_w = rnd_q + 7'(u);
      for (int j = 0; j < 4; j++) begin
        mx_w[64*(2*j) +: 64]   = v_w[64*(2*j) +: 64] + v_w[64*(2*j+1) +: 64];
        mx_w[64*(2*j+1) +: 64] = rotl64(v_w[64*(2*j+1) +: 64], rot_amt(d_w[2:0], 2'(j)))
                                 ^ mx_w[64*(2*j) +: 64];
      end
      for (int i = 0; i < 8; i++) v_w[64*i +: 64] = mx_w[64*PI[i] +: 64];
      // Every fourth round: inject the subkey at the head of the rotating schedule.
      if (d_w[1:0] == 2'd3) begin
        s_w = 5'((d_w + 7'd1) >> 2);
        for (int i = 0; i < 8; i++) begin
          sk_w = k_w[64*i +: 64];
          if (i == 5) sk_w = sk_w + t_w[63:0];
          if (i == 6) sk_w = sk_w + t_w[127:64];
          if (i == 7) sk_w = sk_w + 64'(s_w);
          v_w[64*i +: 64] = v_w[64*i +: 64] + sk_w;
        end
        k_w = {k_w[63:0], k_w[575:64]};
        t_w = {t_w[63:0], t_w[191:64]};
      end
    end
  end

  assign res_w = (FEED_FORWARD != 0) ? (v_w ^ msg_q) : v_w;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    out_d   = out_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_RUN;
      S_RUN: begin
        if (last_run) begin
          state_d = S_DONE;
          out_d   = res_w;
        end
      end
      S_DONE: if (out_ready) state_d = accept ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (accept) rnd_d = '0;
    else if (state_q == S_RUN) rnd_d = rnd_q + STEP;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rnd_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      out_q   <= out_d;
    end
  end

  // NOTE: the wide datapath has no reset; it is loaded on every accept and is only
  // observed through out_q, which is reset and written solely at the end of RUN.
  always_ff @(posedge clk) begin
    if (accept) begin
      v_q   <= v0_w;
      key_q <= key_ld_w;
      tw_q  <= tw_ld_w;
      msg_q <= in_msg;
    end else if (state_q == S_RUN) begin
      v_q   <= v_w;
      key_q <= k_w;
      tw_q  <= t_w;
    end
  end

endmodule

// File: tb/tb_skein512_ubi_iter.sv
// Self-checking bench: scoreboard against a direct Threefish-512/UBI model, plus
// side instances for UNROLL 1/2/8 and raw-cipher mode.
module tb_skein512_ubi_iter;

  localparam int AUX_UN [4] = '{1, 2, 8, 4};
  localparam int AUX_FF [4] = '{1, 1, 1, 0};
  localparam int ROT [8][4] = '{'{46, 36, 19, 37}, '{33, 27, 14, 42}, '{17, 49, 36, 39},
                                '{44, 9, 54, 56},  '{39, 30, 34, 24}, '{13, 50, 10, 17},
                                '{25, 29, 39, 43}, '{8, 35, 56, 22}};
  localparam int PERM [8] = '{2, 1, 4, 7, 6, 5, 0, 3};
  localparam logic [511:0] SKEIN_IV = {
    64'hAE18A40B660FCC33, 64'h991112C71A75B523, 64'hEABE394CA9D5C3F4, 64'h5DB62599DF6CA7B0,
    64'h9A255629FF352CB1, 64'h8FD1934127C79BCE, 64'h0D95DE399746DF03, 64'h4903ADFF749C51CE};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [511:0] in_key, in_msg, out_data;
  logic [127:0] in_tweak;

  logic         aux_valid, aux_out_ready;
  logic         aux_in_ready [4];
  logic         aux_out_valid [4];
  logic         aux_busy [4];
  logic [511:0] aux_out_data [4];

  int n_checks = 0;
  int n_pass   = 0;
  int n_acc    = 0;
  int n_out    = 0;
  logic [511:0] exp_q [$];

  always #5 clk = ~clk;

  skein512_ubi_iter #(.UNROLL(4), .FEED_FORWARD(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_key(in_key), .in_tweak(in_tweak), .in_msg(in_msg),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  generate
    for (genvar g = 0; g < 4; g++) begin : g_aux
      skein512_ubi_iter #(.UNROLL(AUX_UN[g]), .FEED_FORWARD(AUX_FF[g])) u_aux (
        .clk(clk), .rst_n(rst_n),
        .in_valid(aux_valid), .in_ready(aux_in_ready[g]),
        .in_key(in_key), .in_tweak(in_tweak), .in_msg(in_msg),
        .out_valid(aux_out_valid[g]), .out_ready(aux_out_ready), .out_data(aux_out_data[g]),
        .busy(aux_busy[g])
      );
    end
  endgenerate

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [63:0] rotl(input logic [63:0] x, input int r);
    return (x << r) | (x >> (64 - r));
  endfunction

  function automatic logic [63:0] subkey(input logic [63:0] k [9], input logic [63:0] t [3],
                                         input int s, input int i);
    logic [63:0] w;
    w = k[(s + i) % 9];
    if (i == 5) w = w + t[s % 3];
    if (i == 6) w = w + t[(s + 1) % 3];
    if (i == 7) w = w + 64'(s);
    return w;
  endfunction

  function automatic logic [511:0] model(input logic [511:0] key, input logic [127:0] tw,
                                         input logic [511:0] msg, input bit ff);
    logic [63:0] k [9];
    logic [63:0] t [3];
    logic [63:0] v [8];
    logic [63:0] x [8];
    logic [511:0] r;
    k[8] = 64'h1BD11BDAA9FC1A22;
    for (int i = 0; i < 8; i++) begin
      k[i] = key[64*i +: 64];
      k[8] = k[8] ^ k[i];
    end
    t[0] = tw[63:0];
    t[1] = tw[127:64];
    t[2] = t[0] ^ t[1];
    for (int i = 0; i < 8; i++) v[i] = msg[64*i +: 64] + subkey(k, t, 0, i);
    for (int d = 0; d < 72; d++) begin
      for (int j = 0; j < 4; j++) begin
        x[2*j]   = v[2*j] + v[2*j+1];
        x[2*j+1] = rotl(v[2*j+1], ROT[d % 8][j]) ^ x[2*j];
      end
      for (int i = 0; i < 8; i++) v[i] = x[PERM[i]];
      if (d % 4 == 3)
        for (int i = 0; i < 8; i++) v[i] = v[i] + subkey(k, t, (d + 1) / 4, i);
    end
    for (int i = 0; i < 8; i++) r[64*i +: 64] = v[i];
    return ff ? (r ^ msg) : r;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Scoreboard: push on accept, pop on output handshake. A reset aborts in-flight blocks.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_out++;
        check("sb_pending", 512'(exp_q.size() != 0), 512'(1));
        if (exp_q.size() != 0) check("sb_data", out_data, exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
        n_acc++;
        exp_q.push_back(model(in_key, in_tweak, in_msg, 1'b1));
      end
    end
  end

  task automatic send(input logic [511:0] k, input logic [127:0] t, input logic [511:0] m);
    int w;
    w = 0;
    @(posedge clk); #1;
    in_key = k; in_tweak = t; in_msg = m; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("send_ready", 512'(in_ready), 512'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int c = 0; c < 400 && exp_q.size() != 0; c++) @(negedge clk);
    @(posedge clk); #1;
    check(tag, 512'(exp_q.size()), 512'(0));
  endtask

  // Drives the main DUT and all side instances with one block; checks latency and data.
  task automatic run_aux(input logic [511:0] k, input logic [127:0] t, input logic [511:0] m,
                         input string tag);
    int lat [5];
    logic [4:0] rdy;
    for (int g = 0; g < 5; g++) lat[g] = -1;
    @(posedge clk); #1;
    rdy = {in_ready, aux_in_ready[3], aux_in_ready[2], aux_in_ready[1], aux_in_ready[0]};
    check({tag, "_ready"}, 512'(rdy), 512'(5'h1f));
    in_key = k; in_tweak = t; in_msg = m;
    in_valid = 1'b1; aux_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; aux_valid = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      for (int g = 0; g < 4; g++) if (lat[g] < 0 && aux_out_valid[g]) lat[g] = c;
      if (lat[4] < 0 && out_valid) lat[4] = c;
      if (lat[0] >= 0 && lat[1] >= 0 && lat[2] >= 0 && lat[3] >= 0 && lat[4] >= 0) break;
    end
    for (int g = 0; g < 4; g++) begin
      check($sformatf("%s_lat_u%0d_ff%0d", tag, AUX_UN[g], AUX_FF[g]),
            512'(lat[g]), 512'(72 / AUX_UN[g]));
      check($sformatf("%s_data_u%0d_ff%0d", tag, AUX_UN[g], AUX_FF[g]),
            aux_out_data[g], model(k, t, m, AUX_FF[g] != 0));
    end
    check({tag, "_lat_main"}, 512'(lat[4]), 512'(18));
    @(posedge clk); #1 aux_out_ready = 1'b1;
    @(posedge clk); #1 aux_out_ready = 1'b0;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] ka, ma, exp_a;
    logic [127:0] ta;
    int base_acc, base_out, cyc;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_key = '0; in_tweak = '0; in_msg = '0;
    aux_valid = 1'b0; aux_out_ready = 1'b0;
    #12;
    check("rst_out_valid", 512'(out_valid), 512'(0));
    check("rst_out_data", out_data, '0);
    check("rst_busy", 512'(busy), 512'(0));
    check("rst_in_ready", 512'(in_ready), 512'(1));
    @(posedge clk); #1 rst_n = 1'b1;

    // Zero KAT and Skein-512-512 IV block across all unroll factors.
    run_aux('0, '0, '0, "kat0");
    run_aux(SKEIN_IV, 128'h7000000000000000_0000000000000001, 512'hFF, "iv");
    drain("drain_kat");

    // Back-pressure in DONE, then overlapped DONE->RUN accept.
    ka = rand512(); ma = rand512(); ta = rand512() >> 384;
    exp_a = model(ka, ta, ma, 1'b1);
    @(posedge clk); #1 out_ready = 1'b0;
    send(ka, ta, ma);
    for (int c = 0; c < 40 && !out_valid; c++) @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_hold_data", out_data, exp_a);
      check("bp_in_ready", 512'(in_ready), 512'(0));
    end
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1;
    in_key = rand512(); in_msg = rand512(); in_tweak = ~ta;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_busy_next", 512'(busy), 512'(1));
    check("bp_out_valid_low", 512'(out_valid), 512'(0));
    drain("drain_bp");

    // Tweak and key all-ones: subkey adds wrap mod 2^64.
    send('1, '1, rand512());
    drain("drain_carry");

    // Random traffic with toggling handshakes and inputs changing every cycle.
    base_acc = n_acc;
    base_out = n_out;
    cyc = 0;
    while (n_acc - base_acc < 16 && cyc < 5000) begin
      @(posedge clk); #1;
      if (n_acc - base_acc >= 16) break;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_key    = rand512();
      in_msg    = rand512();
      in_tweak  = rand512() >> 384;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain("drain_rand");
    check("rand_accepts", 512'(n_acc - base_acc), 512'(16));
    check("rand_outputs", 512'(n_out - base_out), 512'(16));

    // Asynchronous reset at RUN cycle 9 aborts the block.
    send(rand512(), rand512() >> 384, rand512());
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 512'(out_valid), 512'(0));
    check("arst_out_data", out_data, '0);
    check("arst_busy", 512'(busy), 512'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    check("arst_in_ready", 512'(in_ready), 512'(1));
    base_out = n_out;
    send(rand512(), rand512() >> 384, rand512());
    drain("drain_after_rst");
    check("arst_next_out", 512'(n_out - base_out), 512'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
